calc_display_ctrl: RTL and testbench
====================================

Name: calc_display_ctrl

Overview:
- Downstream consumer of the calculator core's serial digit stream (status/data/pos).
- Captures one 8-digit frame per print burst into a shadow buffer and commits it atomically, so partial bursts never tear the display.
- Drives 8 multiplexed common-anode seven-segment digits, with leading-zero blanking and an "Erro" screen when the core reports error.

Parameters:
- SCAN_DIV, 100000: clock cycles each digit stays lit; legal range ≥2.
- BLANK_ZEROS, 1: 1 blanks leading zeros on digits 7..1; 0 shows all 8 digits.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- status  in  2  core status: 00 error, 01 busy, 10 ready, 11 printing.
- data  in  4  BCD digit from the core; valid while status=11.
- pos  in  4  core position counter; pos=k (1..8) means data holds digit k-1 (digit 0 = least significant).
- an  out  8  digit anodes, active-low, one-hot-low; an[i] enables digit i.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; always 1 (off).
- frame_ok  out  1  one-cycle pulse on each successful commit.

Behaviour:
- Reset (reset=0, async):
  - an=8'hFF, seg=7'h7F, dp=1, frame_ok=0.
  - Shadow and display buffers all 0; capture mask 0; scan counter 0; digit index 0.
  - mode=SHOW; status_q=10.
- Capture, every cycle with status=11 and 1≤pos≤8:
  - shadow[pos-1] <= data; mask[pos-1] <= 1.
  - data>9 is stored as the blank code.
  - pos=0 or pos>8: no write.
- Commit, on a cycle where status_q=11 and status≠11 (status_q = status registered one cycle):
  - mask=8'hFF: display buffer <= shadow on that edge; frame_ok=1 for that cycle; mode=SHOW.
  - Otherwise: display buffer unchanged; no pulse.
  - In both cases the mask clears to 0.
- Error: status=00 sets mode=ERR on the next edge.
  - ERR shows digits 3..0 = E,r,r,o and blanks digits 7..4.
  - The display buffer is retained.
  - status=11 returns mode to SHOW immediately and starts a new capture.
  - status 01/10 keeps ERR.
- Mode FSM: SHOW → ERR when status=00; ERR → SHOW when status=11.
  - A commit also forces SHOW.
  - Error and commit on the same edge: error wins.
- Scan:
  - Counter runs 0..SCAN_DIV-1; on wrap, the digit index increments mod 8 (7→0).
  - an and seg are registered: they reflect the new index one cycle after it changes.
  - Exactly one an bit is low at any time after the first post-reset edge.
- Blanking (BLANK_ZEROS=1, SHOW mode only):
  - Digit i (i≥1) is blank if it and every digit above it are 0.
  - Digit 0 is never blanked, so value 0 shows "0".
  - Evaluated combinationally from the display buffer each cycle.
- Segment codes (hex, active-low gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - E=06, r=2F, o=23, blank=7F.
- Simultaneous capture write and commit on the same edge cannot occur: status=11 and status≠11 are exclusive.
- A reset mid-burst discards the shadow buffer.
- The display buffer only ever changes on a full commit.

Test Plan:
- Full frame: reset, then status=11 with pos=1..8 and data=4,3,2,1,0,0,0,0, then status=10 → frame_ok pulses once; display reads "1234"; an cycles FE,FD,FB,F7 showing seg 19,30,24,79; digits 7..4 are 7F.
- Partial frame: after the test above, a burst with pos=1..5 only, then status=10 → no frame_ok; display still shows "1234".
- Zero value with blanking: commit a frame of all 0 → digit 0 seg=40; digits 1..7 seg=7F. With BLANK_ZEROS=0, all eight digits show 40.
- Error: status=00 → within 2 cycles digits 3..0 show 06,2F,2F,23 and digits 7..4 show 7F. Then a full frame of 9s followed by status=10 → all digits show 10.
- Scan wrap (SCAN_DIV=4): an sequence FE→FD→…→7F→FE, each held exactly 4 cycles.
- Async reset mid-burst: drive reset=0 at pos=3 → an=FF and seg=7F without waiting for a clock edge. After release, a full frame commits normally.

Source files
------------

// File: rtl/calc_display_ctrl.sv
// calc_display_ctrl: captures serial BCD frames from the calculator core
// and scans them onto 8 multiplexed common-anode seven-segment digits.
module calc_display_ctrl #(
    parameter int SCAN_DIV    = 100000,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_ok
);

    localparam int CW = $clog2(SCAN_DIV);

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_READY = 2'b10;
    localparam logic [1:0] ST_PRINT = 2'b11;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_O     = 7'h23;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        SHOW,
        ERR
    } mode_t;

    logic [3:0]    r_shadow [8];
    logic [3:0]    r_disp   [8];
    logic [7:0]    r_mask;
    logic [1:0]    r_status_q;
    mode_t         r_mode;
    mode_t         w_mode_nxt;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;

    logic          w_cap;
    logic [2:0]    w_wr_idx;
    logic          w_commit;
    logic          w_full;
    logic [7:0]    w_blank;
    logic [6:0]    w_seg_nxt;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign w_cap    = (status == ST_PRINT) && (pos != 4'd0) && (pos <= 4'd8);
    assign w_wr_idx = 3'(pos - 4'd1);
    assign w_commit = (r_status_q == ST_PRINT) && (status != ST_PRINT);
    assign w_full   = w_commit && (r_mask == 8'hFF);

    assign frame_ok = w_full;
    assign dp       = 1'b1;
    assign an       = r_an;
    assign seg      = r_seg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_status_q <= ST_READY;
        end else begin
            r_status_q <= status;
        end
    end

    // Shadow collects one burst; the mask proves every digit arrived.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                r_shadow[i] <= 4'd0;
            end
            r_mask <= 8'h00;
        end else if (w_cap) begin
            r_shadow[w_wr_idx] <= (data > 4'd9) ? BLANK_CODE : data;
            r_mask[w_wr_idx]   <= 1'b1;
        end else if (w_commit) begin
            r_mask <= 8'h00;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                r_disp[i] <= 4'd0;
            end
        end else if (w_full) begin
            for (int i = 0; i < 8; i++) begin
                r_disp[i] <= r_shadow[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mode <= SHOW;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    // Error takes priority over a commit landing on the same edge.
    always_comb begin
        w_mode_nxt = r_mode;
        if (status == ST_ERR) begin
            w_mode_nxt = ERR;
        end else if ((status == ST_PRINT) || w_commit) begin
            w_mode_nxt = SHOW;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
        end else if (r_cnt == CW'(SCAN_DIV - 1)) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // w_blank[i]: digit i and everything above it are zero.
    always_comb begin
        w_blank    = 8'h00;
        w_blank[7] = (r_disp[7] == 4'd0);
        for (int i = 6; i >= 1; i--) begin
            w_blank[i] = w_blank[i+1] && (r_disp[i] == 4'd0);
        end
        w_blank[0] = 1'b0;
    end

    always_comb begin
        w_seg_nxt = SEG_BLANK;
        if (r_mode == ERR) begin
            case (r_idx)
                3'd3:    w_seg_nxt = SEG_E;
                3'd2:    w_seg_nxt = SEG_R;
                3'd1:    w_seg_nxt = SEG_R;
                3'd0:    w_seg_nxt = SEG_O;
                default: w_seg_nxt = SEG_BLANK;
            endcase
        end else if (BLANK_ZEROS && w_blank[r_idx]) begin
            w_seg_nxt = SEG_BLANK;
        end else begin
            w_seg_nxt = seg_of(r_disp[r_idx]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_an  <= 8'hFF;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= ~(8'd1 << r_idx);
            r_seg <= w_seg_nxt;
        end
    end

endmodule

// File: tb/tb_calc_display_ctrl.sv
// tb_calc_display_ctrl: randomized scoreboard bench for calc_display_ctrl
// against a digit-level model of capture, commit, error and blanking.
`timescale 1ns/1ps
module tb_calc_display_ctrl;

    localparam int SD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] status = 2'b10;
    logic [3:0] data = 4'd0;
    logic [3:0] pos = 4'd0;

    logic [7:0] an, an_nb;
    logic [6:0] seg, seg_nb;
    logic       dp, dp_nb;
    logic       fok, fok_nb;

    always #5 clock = ~clock;

    calc_display_ctrl #(.SCAN_DIV(SD), .BLANK_ZEROS(1'b1)) dut (
        .clock(clock), .reset(reset), .status(status), .data(data),
        .pos(pos), .an(an), .seg(seg), .dp(dp), .frame_ok(fok)
    );

    calc_display_ctrl #(.SCAN_DIV(SD), .BLANK_ZEROS(1'b0)) dut_nb (
        .clock(clock), .reset(reset), .status(status), .data(data),
        .pos(pos), .an(an_nb), .seg(seg_nb), .dp(dp_nb), .frame_ok(fok_nb)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0][6:0] a;
        logic [7:0][6:0] b;
    } scr_t;

    scr_t q_scr[$];
    int   q_ok[$];

    int m_disp[8];
    int m_shadow[8];
    bit m_err;

    int g_pos[$];
    int g_dat[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic scr_t expect_screen();
        scr_t s;
        int   top;
        top = 0;
        for (int i = 0; i < 8; i++)
            if (m_disp[i] != 0) top = i;
        for (int i = 0; i < 8; i++) begin
            if (m_err) begin
                case (i)
                    3: s.a[i] = 7'h06;
                    2: s.a[i] = 7'h2F;
                    1: s.a[i] = 7'h2F;
                    0: s.a[i] = 7'h23;
                    default: s.a[i] = 7'h7F;
                endcase
                s.b[i] = s.a[i];
            end else begin
                s.b[i] = glyph(m_disp[i]);
                s.a[i] = (i > top) ? 7'h7F : glyph(m_disp[i]);
            end
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_disp[i]   = 0;
            m_shadow[i] = 0;
        end
        m_err = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic check_screen();
        int guard;
        repeat (3) step();
        chk("frame_ok_pending", q_ok.size(), 0);
        q_ok.delete();
        q_scr.push_back(expect_screen());
        guard = 0;
        while (q_scr.size() > 0 && guard < 24 * SD) begin
            step();
            guard++;
        end
        if (q_scr.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL screen_timeout pending %0d expected 0", q_scr.size());
            q_scr.delete();
        end
    endtask

    // Drives the queued writes, then ends the burst with end_st.
    task automatic burst(input logic [1:0] end_st);
        bit seen[8];
        int p, d;
        bit all;
        for (int i = 0; i < 8; i++) seen[i] = 0;
        m_err  = 0;
        status = 2'b11;
        while (g_pos.size() > 0) begin
            p    = g_pos.pop_front();
            d    = g_dat.pop_front();
            pos  = 4'(p);
            data = 4'(d);
            step();
            if (p >= 1 && p <= 8) begin
                m_shadow[p-1] = (d > 9) ? 15 : d;
                seen[p-1] = 1;
            end
        end
        all = 1;
        for (int i = 0; i < 8; i++) all &= seen[i];
        if (all) begin
            for (int i = 0; i < 8; i++) m_disp[i] = m_shadow[i];
            q_ok.push_back(1);
        end
        if (end_st == 2'b00) m_err = 1;
        status = end_st;
        pos    = 4'd0;
        step();
        status = 2'b10;
        check_screen();
    endtask

    function automatic int rnd_digit();
        if ($urandom % 8 == 0) return 10 + int'($urandom % 6);
        return int'($urandom % 10);
    endfunction

    task automatic queue_full_random();
        int perm[8];
        int j, t;
        for (int i = 0; i < 8; i++) perm[i] = i + 1;
        for (int i = 7; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int i = 0; i < 8; i++) begin
            if ($urandom % 4 == 0) begin
                g_pos.push_back(($urandom % 2 == 0) ? 0 : 9 + int'($urandom % 7));
                g_dat.push_back(int'($urandom % 16));
            end
            g_pos.push_back(perm[i]);
            g_dat.push_back(rnd_digit());
        end
    endtask

    task automatic queue_partial_random();
        int miss, n, p;
        miss = 1 + int'($urandom % 8);
        n    = 3 + int'($urandom % 8);
        for (int k = 0; k < n; k++) begin
            p = int'($urandom % 16);
            if (p == miss) p = 0;
            g_pos.push_back(p);
            g_dat.push_back(rnd_digit());
        end
    endtask

    // Scoreboard monitor for commit pulses.
    always @(negedge clock) begin
        if (reset && fok) begin
            checks++;
            if (q_ok.size() == 0) begin
                errors++;
                $display("FAIL frame_ok got 1 expected 0 at %0t", $time);
            end else begin
                void'(q_ok.pop_front());
            end
        end
    end

    // Screen monitor: compares each digit once per pushed screen.
    bit mseen[8];
    always @(negedge clock) begin
        bit done;
        if (!reset || q_scr.size() == 0) begin
            for (int i = 0; i < 8; i++) mseen[i] = 0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (an == ~(8'd1 << i) && !mseen[i]) begin
                    mseen[i] = 1;
                    chk($sformatf("seg_d%0d", i), 32'(seg), 32'(q_scr[0].a[i]));
                    chk($sformatf("seg_nb_d%0d", i), 32'(seg_nb), 32'(q_scr[0].b[i]));
                end
            end
            done = 1;
            for (int i = 0; i < 8; i++) done &= mseen[i];
            if (done) begin
                void'(q_scr.pop_front());
                for (int i = 0; i < 8; i++) mseen[i] = 0;
            end
        end
    end

    // Scan monitor: each anode change is a rotate by one after SD cycles.
    logic [7:0] prev_an = 8'hFF;
    int         run = 0;
    always @(negedge clock) begin
        if (!reset) begin
            prev_an = 8'hFF;
            run     = 0;
        end else if (an == prev_an) begin
            run++;
        end else begin
            if (prev_an == 8'hFF) begin
                chk("scan_first", 32'(an), 32'hFE);
            end else begin
                chk("scan_rotate", 32'(an), 32'({prev_an[6:0], prev_an[7]}));
                chk("scan_hold", run, SD);
            end
            chk("scan_onehot", $countones(~an), 1);
            prev_an = an;
            run     = 1;
        end
    end

    initial begin
        model_reset();
        reset  = 1'b0;
        status = 2'b10;
        repeat (2) step();
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 1);
        chk("rst_frame_ok", 32'(fok), 0);
        reset = 1'b1;
        check_screen();

        for (int i = 0; i < 8; i++) begin
            g_pos.push_back(i + 1);
            g_dat.push_back((i < 4) ? 4 - i : 0);
        end
        burst(2'b10);

        for (int i = 0; i < 5; i++) begin
            g_pos.push_back(i + 1);
            g_dat.push_back(7);
        end
        burst(2'b10);

        for (int i = 0; i < 8; i++) begin
            g_pos.push_back(i + 1);
            g_dat.push_back(0);
        end
        burst(2'b10);

        status = 2'b00;
        step();
        m_err  = 1;
        status = 2'b10;
        check_screen();
        status = 2'b01;
        check_screen();

        for (int i = 0; i < 8; i++) begin
            g_pos.push_back(i + 1);
            g_dat.push_back(9);
        end
        burst(2'b10);

        status = 2'b11;
        for (int p = 1; p <= 3; p++) begin
            pos  = 4'(p);
            data = 4'd5;
            if (p < 3) step();
        end
        #1;
        reset = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'hFF);
        chk("async_seg", 32'(seg), 32'h7F);
        chk("async_frame_ok", 32'(fok), 0);
        model_reset();
        status = 2'b10;
        pos    = 4'd0;
        step();
        step();
        reset = 1'b1;
        check_screen();
        queue_full_random();
        burst(2'b10);

        for (int it = 0; it < 40; it++) begin
            case ($urandom % 5)
                0, 1: begin
                    queue_full_random();
                    burst(($urandom % 4 == 0) ? 2'b00 : 2'($urandom_range(1, 2)));
                end
                2: begin
                    queue_partial_random();
                    burst(2'($urandom_range(0, 2)));
                end
                3: begin
                    status = 2'b00;
                    step();
                    m_err  = 1;
                    status = 2'($urandom_range(1, 2));
                    check_screen();
                end
                default: begin
                    status = 2'($urandom_range(1, 2));
                    check_screen();
                end
            endcase
        end

        repeat (4) step();
        chk("frame_ok_final", q_ok.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
